// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT_PEND,
    S_HALTED,
    S_FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: words captured and decode-stall cycles.
// Only exists when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters
  import fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            capture,
  input  logic            stall,
  output logic [XLEN-1:0] fetch_count,
  output logic [XLEN-1:0] stall_count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (capture) fetch_count <= fetch_count + 32'd1;
      if (stall)   stall_count <= stall_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction RAM, and hands words to decode.
// Optional perf counters are built when FETCH_PERF_EN is defined.
module instr_fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     ADDR_W    = 9,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  output logic [ADDR_W-1:0] FETCH_ADDRESS,
  output logic              STOP,
  input  logic [XLEN-1:0]   RAM_DATA,
  output logic [XLEN-1:0]   INSTR,
  output logic [XLEN-1:0]   INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  input  logic              REDIRECT_VALID,
  input  logic [XLEN-1:0]   REDIRECT_PC,
  output logic              HALTED,
  output logic              FAULT,
  output logic [XLEN-1:0]   FETCH_COUNT,
  output logic [XLEN-1:0]   STALL_COUNT
);

  fetch_state_e      state, state_next;
  logic [XLEN-1:0]   pc, instr_q, instr_pc_q, redirect_target;
  logic              instr_valid_q;
  logic [ADDR_W-1:0] last_addr;
  logic              slot_free, in_range, redirect, fetch;

  always_comb begin
    slot_free       = !instr_valid_q || INSTR_READY;
    in_range        = (pc[XLEN-1:ADDR_W+2] == '0);
    redirect        = REDIRECT_VALID && (state != S_HALTED);
    redirect_target = REDIRECT_PC & ~32'h3;
    fetch           = !redirect && (state == S_RUN) && slot_free && in_range;

    state_next    = state;
    STOP          = !fetch;
    // The RAM address only moves on an issued fetch so the frozen RAM sees a stable index.
    FETCH_ADDRESS = fetch ? pc[ADDR_W+1:2] : last_addr;

    if (redirect) begin
      state_next = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (fetch && (RAM_DATA == HALT_WORD)) state_next = S_HALT_PEND;
          else if (slot_free && !in_range)      state_next = S_FAULT;
        end
        S_HALT_PEND: begin
          if (instr_valid_q && INSTR_READY) state_next = S_HALTED;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state <= S_RUN;
    else          state <= state_next;
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      pc            <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      last_addr     <= RESET_PC[ADDR_W+1:2];
    end else if (redirect) begin
      instr_valid_q <= 1'b0;
      pc            <= redirect_target;
    end else if (fetch) begin
      instr_q       <= RAM_DATA;
      instr_pc_q    <= pc;
      instr_valid_q <= 1'b1;
      pc            <= pc + 32'd4;
      last_addr     <= pc[ADDR_W+1:2];
    end else if (INSTR_READY) begin
      instr_valid_q <= 1'b0;
    end
  end

  assign INSTR       = instr_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = instr_valid_q;
  assign HALTED      = (state == S_HALTED);
  assign FAULT       = (state == S_FAULT);

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk         (CLOCK),
    .rst_n       (RESET_N),
    .capture     (fetch),
    .stall       (instr_valid_q && !INSTR_READY),
    .fetch_count (FETCH_COUNT),
    .stall_count (STALL_COUNT)
  );
`else
  assign FETCH_COUNT = '0;
  assign STALL_COUNT = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: per-cycle vector table plus a handshake scoreboard.
module tb_instr_fetch_ctrl;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [8:0]  FETCH_ADDRESS;
  logic        STOP;
  logic [31:0] RAM_DATA;
  logic [31:0] INSTR, INSTR_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b0;
  logic        REDIRECT_VALID = 1'b0;
  logic [31:0] REDIRECT_PC = '0;
  logic        HALTED, FAULT;
  logic [31:0] FETCH_COUNT, STALL_COUNT;

  logic [31:0] ram [512];
  assign RAM_DATA = ram[FETCH_ADDRESS];

  instr_fetch_ctrl #(.ADDR_W(9), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .FETCH_ADDRESS(FETCH_ADDRESS), .STOP(STOP),
    .RAM_DATA(RAM_DATA), .INSTR(INSTR), .INSTR_PC(INSTR_PC), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_PC(REDIRECT_PC),
    .HALTED(HALTED), .FAULT(FAULT), .FETCH_COUNT(FETCH_COUNT), .STALL_COUNT(STALL_COUNT)
  );

  always #5 CLOCK = ~CLOCK;

  // kind: 0 = one clocked cycle, 1 = reset cycle, 2 = counter check (no clock)
  typedef struct packed {
    logic [1:0]  kind;
    logic        rdy, rv;
    logic [31:0] rpc;
    logic        stop;
    logic [8:0]  fa;
    logic        valid;
    logic [31:0] instr, pc;
    logic        fault, halted;
    logic [31:0] fc, sc;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic vec_t V(logic rdy, logic rv, logic [31:0] rpc, logic stop, logic [8:0] fa,
                             logic valid, logic [31:0] instr, logic [31:0] pc,
                             logic fault, logic halted);
    vec_t v;
    v = '0;
    v.kind = 2'd0; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.stop = stop; v.fa = fa;
    v.valid = valid; v.instr = instr; v.pc = pc; v.fault = fault; v.halted = halted;
    return v;
  endfunction

  function automatic vec_t R();
    vec_t v;
    v = '0;
    v.kind = 2'd1;
    return v;
  endfunction

  function automatic vec_t C(logic [31:0] fc, logic [31:0] sc);
    vec_t v;
    v = '0;
    v.kind = 2'd2; v.fc = fc; v.sc = sc;
    return v;
  endfunction

  // Every accepted word must match the next expectation queued by the stimulus loop.
  always @(negedge CLOCK) begin
    if (RESET_N && INSTR_VALID && INSTR_READY && !REDIRECT_VALID) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL handshake: unexpected INSTR %0h PC %0h, required no handshake", INSTR, INSTR_PC);
      end else begin
        chk("handshake", {INSTR, INSTR_PC}, sb_q.pop_front());
      end
    end
  end

  initial begin
    vec_t        v;
    logic        prev_valid;
    logic [63:0] prev_exp;
    logic [31:0] efc, esc;

    for (int unsigned a = 0; a < 512; a++) ram[a] = '0;
    ram[0] = 32'h11; ram[1] = 32'h22; ram[2] = 32'h33; ram[3] = 32'h44;
    ram[4] = 32'h55; ram[5] = 32'hFFFF_FFFF;
    ram[64] = 32'hA0A0_0040; ram[65] = 32'hA0A0_0041;

    // back-to-back fetch
    vecs.push_back(R());
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h11, 32'h0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 1, 1, 32'h22, 32'h4, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 2, 1, 32'h33, 32'h8, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 3, 1, 32'h44, 32'hC, 0, 0));
    // 3-cycle decode stall on 0x22
    vecs.push_back(R());
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h11, 32'h0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 1, 1, 32'h22, 32'h4, 0, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(V(0, 0, 0, 1, 1, 1, 32'h22, 32'h4, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 2, 1, 32'h33, 32'h8, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 3, 1, 32'h44, 32'hC, 0, 0));
    vecs.push_back(C(4, 3));
    // redirect to 0x103
    vecs.push_back(R());
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h11, 32'h0, 0, 0));
    vecs.push_back(V(0, 1, 32'h103, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 64, 1, 32'hA0A0_0040, 32'h100, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 65, 1, 32'hA0A0_0041, 32'h104, 0, 0));
    // halt word at word 5, accepted late, redirect ignored afterwards
    vecs.push_back(R());
    for (int k = 0; k < 5; k++)
      vecs.push_back(V(1, 0, 0, 0, 9'(k), 1, 32'(k + 1) * 32'h11, 32'(4 * k), 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 5, 1, 32'hFFFF_FFFF, 32'h14, 0, 0));
    vecs.push_back(V(0, 0, 0, 1, 5, 1, 32'hFFFF_FFFF, 32'h14, 0, 0));
    vecs.push_back(V(1, 0, 0, 1, 5, 0, 0, 0, 0, 1));
    vecs.push_back(V(1, 1, 0, 1, 5, 0, 0, 0, 0, 1));
    vecs.push_back(V(1, 0, 0, 1, 5, 0, 0, 0, 0, 1));
    vecs.push_back(C(6, 1));
    // wrong-path halt word cancelled by redirect
    vecs.push_back(R());
    for (int k = 0; k < 5; k++)
      vecs.push_back(V(1, 0, 0, 0, 9'(k), 1, 32'(k + 1) * 32'h11, 32'(4 * k), 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 5, 1, 32'hFFFF_FFFF, 32'h14, 0, 0));
    vecs.push_back(V(0, 1, 32'h10, 1, 5, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 4, 1, 32'h55, 32'h10, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 5, 1, 32'hFFFF_FFFF, 32'h14, 0, 0));
    // out-of-range fault and recovery
    vecs.push_back(R());
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h11, 32'h0, 0, 0));
    vecs.push_back(V(0, 1, 32'h800, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(1, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(V(0, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(V(1, 0, 0, 0, 0, 1, 32'h11, 32'h0, 0, 0));
    vecs.push_back(R());

    prev_valid = 1'b0;
    prev_exp   = '0;
    foreach (vecs[i]) begin
      v = vecs[i];
      case (v.kind)
        2'd1: begin
          RESET_N = 1'b0; INSTR_READY = 1'b0; REDIRECT_VALID = 1'b0; REDIRECT_PC = '0;
          @(posedge CLOCK); #1;
          chk($sformatf("row%0d reset valid/halted/fault", i), {61'd0, INSTR_VALID, HALTED, FAULT}, 64'd0);
          chk($sformatf("row%0d reset instr/pc", i), {INSTR, INSTR_PC}, 64'd0);
          chk($sformatf("row%0d reset counters", i), {FETCH_COUNT, STALL_COUNT}, 64'd0);
          prev_valid = 1'b0;
        end
        2'd2: begin
`ifdef FETCH_PERF_EN
          efc = v.fc; esc = v.sc;
`else
          efc = '0; esc = '0;
`endif
          chk($sformatf("row%0d fetch_count", i), 64'(FETCH_COUNT), 64'(efc));
          chk($sformatf("row%0d stall_count", i), 64'(STALL_COUNT), 64'(esc));
        end
        default: begin
          RESET_N = 1'b1; INSTR_READY = v.rdy; REDIRECT_VALID = v.rv; REDIRECT_PC = v.rpc;
          if (v.rdy && !v.rv && prev_valid) sb_q.push_back(prev_exp);
          #1;
          chk($sformatf("row%0d stop", i), 64'(STOP), 64'(v.stop));
          chk($sformatf("row%0d fetch_address", i), 64'(FETCH_ADDRESS), 64'(v.fa));
          @(posedge CLOCK); #1;
          chk($sformatf("row%0d valid/halted/fault", i), {61'd0, INSTR_VALID, HALTED, FAULT},
              {61'd0, v.valid, v.halted, v.fault});
          if (v.valid) chk($sformatf("row%0d instr/pc", i), {INSTR, INSTR_PC}, {v.instr, v.pc});
          prev_valid = v.valid;
          prev_exp   = {v.instr, v.pc};
        end
      endcase
    end

    // reset wins over a simultaneous redirect
    RESET_N = 1'b0; INSTR_READY = 1'b1; REDIRECT_VALID = 1'b1; REDIRECT_PC = 32'h40;
    @(posedge CLOCK); #1;
    chk("reset over redirect valid", 64'(INSTR_VALID), 64'd0);
    RESET_N = 1'b1; REDIRECT_VALID = 1'b0;
    @(posedge CLOCK); #1;
    INSTR_READY = 1'b0;
    chk("reset over redirect word", {INSTR, INSTR_PC}, {32'h11, 32'h0});
    chk("reset over redirect valid after", 64'(INSTR_VALID), 64'd1);
    @(posedge CLOCK); #1;
    chk("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
